// File: rtl/wave_gen_pkg.sv
// Shared encodings, constants and the sine table generator for wave_gen.
package wave_gen_pkg;
  localparam int DEF_PHASE_W = 32;
  localparam int DEF_LUT_AW  = 8;

  localparam logic [15:0]        AMP_ONE = 16'h8000;
  localparam logic signed [15:0] SQ_POS  = 16'sd32767;
  localparam real                PI      = 3.141592653589793;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // First pipeline stage snapshot: everything a sample needs travels together.
  typedef struct packed {
    logic [15:0] p;
    wave_e       sel;
    logic [15:0] amp;
  } s1_t;

  // Quarter-wave magnitude, sampled at bin centres; evaluated at elaboration only.
  function automatic logic [14:0] sine_mag(input int a, input int aw);
    real x;
    x = 32767.0 * $sin(PI / 2.0 * (real'(a) + 0.5) / real'(2 ** aw));
    return 15'($rtoi(x + 0.5));
  endfunction
endpackage

// File: rtl/wave_gen_if.sv
// Control/data bundle between wave_gen and its host / FIR consumer.
interface wave_gen_if import wave_gen_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W
);
  logic               enable;
  logic               sample_tick;
  logic               phase_clr;
  logic               cfg_load;
  logic [PHASE_W-1:0] freq_word;
  logic [1:0]         wave_sel;
  logic [15:0]        amplitude;
  logic [15:0]        data_out;
  logic               data_valid;
  logic               wrap;

  modport master (
    output enable, sample_tick, phase_clr, cfg_load, freq_word, wave_sel, amplitude,
    input  data_out, data_valid, wrap
  );

  modport slave (
    input  enable, sample_tick, phase_clr, cfg_load, freq_word, wave_sel, amplitude,
    output data_out, data_valid, wrap
  );
endinterface

// File: rtl/wave_gen_sine_rom.sv
// Synchronous-read quarter-wave sine magnitude table (one cycle latency).
module sine_quarter_rom import wave_gen_pkg::*; #(
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LUT_AW-1:0] addr,
  output logic [14:0]       mag
);
  logic [14:0] tab [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_tab
    localparam logic [14:0] V = sine_mag(i, LUT_AW);
    assign tab[i] = V;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mag <= '0;
    else          mag <= tab[addr];
  end
endmodule

// File: rtl/wave_gen.sv
// NCO waveform source: phase accumulator, wrap-aligned config, 3-stage shape/scale pipe.
module wave_gen import wave_gen_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW  = DEF_LUT_AW
) (
  input  logic      clk,
  input  logic      reset_n,
  wave_gen_if.slave bus
);
  localparam int STAGES = 3;

  logic [PHASE_W-1:0] phase, phase_cur, shadow_freq, active_freq;
  logic [PHASE_W:0]   sum;
  wave_e              shadow_sel, active_sel;
  logic [15:0]        shadow_amp, active_amp, amp_clamped;
  logic               pending, accept, carry, apply;
  logic [STAGES:1]    vld_pipe;

  assign accept    = bus.enable & bus.sample_tick;
  assign phase_cur = bus.phase_clr ? '0 : phase;
  assign sum       = {1'b0, phase_cur} + {1'b0, active_freq};
  assign carry     = accept & sum[PHASE_W];
  // Config only switches at a period boundary, or immediately while stalled.
  assign apply     = pending & (carry | ~bus.enable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.wrap <= carry;
      if (accept)             phase <= sum[PHASE_W-1:0];
      else if (bus.phase_clr) phase <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_freq <= '0;
      shadow_sel  <= WAVE_SINE;
      shadow_amp  <= '0;
      active_freq <= '0;
      active_sel  <= WAVE_SINE;
      active_amp  <= '0;
      pending     <= 1'b0;
    end else begin
      if (apply) begin
        active_freq <= shadow_freq;
        active_sel  <= shadow_sel;
        active_amp  <= shadow_amp;
      end
      if (bus.cfg_load) begin
        shadow_freq <= bus.freq_word;
        shadow_sel  <= wave_e'(bus.wave_sel);
        shadow_amp  <= bus.amplitude;
      end
      pending <= bus.cfg_load | (pending & ~apply);
    end
  end

  // S1: snapshot phase/shape/gain
  s1_t s1;
  assign amp_clamped = (active_amp > AMP_ONE) ? AMP_ONE : active_amp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) s1 <= '{p: phase_cur[PHASE_W-1 -: 16], sel: active_sel, amp: amp_clamped};
    end
  end

  // S2: ROM read in parallel with the arithmetic shapes
  logic [14:0]        fold, rom_mag;
  logic [LUT_AW-1:0]  rom_addr;
  logic signed [15:0] shape, s2_shape;
  logic               s2_sine, s2_neg;
  logic [15:0]        s2_amp;

  assign fold     = s1.p[15] ? ~s1.p[14:0] : s1.p[14:0];
  assign rom_addr = s1.p[14] ? ~s1.p[13 -: LUT_AW] : s1.p[13 -: LUT_AW];

  always_comb begin
    shape = '0;
    case (s1.sel)
      WAVE_SQUARE: shape = s1.p[15] ? -SQ_POS : SQ_POS;
      WAVE_TRI:    shape = {~fold[14], fold[13:0], 1'b0};
      WAVE_SAW:    shape = {~s1.p[15], s1.p[14:0]};
      default:     shape = '0;
    endcase
  end

  sine_quarter_rom #(.LUT_AW(LUT_AW)) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (rom_addr),
    .mag     (rom_mag)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_shape <= '0;
      s2_sine  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_amp   <= '0;
    end else begin
      s2_shape <= shape;
      s2_sine  <= (s1.sel == WAVE_SINE);
      s2_neg   <= s1.p[15];
      s2_amp   <= s1.amp;
    end
  end

  // S3: sine sign applied here since the magnitude only lands out of the ROM register
  logic signed [15:0] wave, sat;
  logic signed [32:0] prod, scaled;

  always_comb begin
    wave   = s2_sine ? (s2_neg ? -signed'({1'b0, rom_mag}) : signed'({1'b0, rom_mag})) : s2_shape;
    prod   = 33'(wave) * signed'({17'd0, s2_amp}) + 33'sd16384;
    scaled = prod >>> 15;
    if (scaled > 33'sd32767)       sat = 16'sh7FFF;
    else if (scaled < -33'sd32768) sat = 16'sh8000;
    else                           sat = scaled[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  bus.data_out <= '0;
    else if (vld_pipe[STAGES-1])   bus.data_out <= sat;
  end

  assign bus.data_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_wave_gen.sv
// Randomized scoreboard bench for wave_gen against a sample-level reference model.
module tb_wave_gen;
  import wave_gen_pkg::*;

  typedef struct { int due; int val; } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  bit   done = 1'b0;
  int   last_out = 0;
  ent_t exp_q[$], wrap_q[$];

  // reference state
  logic [31:0] m_phase, m_freq, sh_freq;
  int          m_sel, sh_sel, m_amp, sh_amp;
  bit          m_pend;

  wave_gen_if #(.PHASE_W(32)) bus();

  wave_gen #(.PHASE_W(32), .LUT_AW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int ref_sample(input int p, input int sel, input int amp);
    int w, idx, m, a;
    longint r;
    case (sel)
      0: begin
        idx = (p >> 6) & 255;
        if ((p & 'h4000) != 0) idx = 255 - idx;
        m = $rtoi(32767.0 * $sin(3.141592653589793 / 2.0 * (real'(idx) + 0.5) / 256.0) + 0.5);
        w = (p >= 32768) ? -m : m;
      end
      1:       w = (p >= 32768) ? -32767 : 32767;
      2:       w = 2 * ((p < 32768) ? p : 65535 - p) - 32768;
      default: w = p - 32768;
    endcase
    a = (amp > 32768) ? 32768 : amp;
    r = (longint'(w) * longint'(a) + 16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic bit will_carry();
    logic [32:0] s;
    s = {1'b0, m_phase} + {1'b0, m_freq};
    return s[32];
  endfunction

  task automatic model_reset();
    m_phase = '0; m_freq = '0; sh_freq = '0;
    m_sel = 0; sh_sel = 0; m_amp = 0; sh_amp = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit tick, input bit clr, input bit ld,
                            input logic [31:0] fw, input int ws, input int amp);
    bit          acc, cy, app;
    logic [31:0] ph;
    logic [32:0] s;
    acc = en && tick;
    ph  = clr ? 32'd0 : m_phase;
    cy  = 1'b0;
    if (acc) begin
      exp_q.push_back('{due: cyc + 3, val: ref_sample(int'(ph[31:16]), m_sel, m_amp)});
      s = {1'b0, ph} + {1'b0, m_freq};
      cy = s[32];
      m_phase = s[31:0];
    end else if (clr) begin
      m_phase = '0;
    end
    wrap_q.push_back('{due: cyc + 1, val: int'(cy)});
    app = m_pend && (cy || !en);
    if (app) begin m_freq = sh_freq; m_sel = sh_sel; m_amp = sh_amp; end
    if (ld) begin
      sh_freq = fw; sh_sel = ws; sh_amp = amp; m_pend = 1'b1;
    end else if (app) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic drive(input bit en, input bit tick, input bit clr, input bit ld,
                       input logic [31:0] fw, input int ws, input int amp);
    bus.enable = en; bus.sample_tick = tick; bus.phase_clr = clr; bus.cfg_load = ld;
    bus.freq_word = fw; bus.wave_sel = 2'(ws); bus.amplitude = 16'(amp);
  endtask

  task automatic step(input bit en, input bit tick, input bit clr, input bit ld,
                      input logic [31:0] fw, input int ws, input int amp);
    @(posedge clk); #1;
    drive(en, tick, clr, ld, fw, ws, amp);
    model_step(en, tick, clr, ld, fw, ws, amp);
  endtask

  task automatic run(input int n);
    repeat (n) step(1, 1, 0, 0, '0, 0, 0);
  endtask

  task automatic load(input logic [31:0] fw, input int ws, input int amp);
    step(0, 0, 0, 1, fw, ws, amp);
    step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0);
    exp_q.delete(); wrap_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // stimulus
  initial begin
    bit ld_done;
    drive(0, 0, 0, 0, '0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_step(0, 0, 0, 0, '0, 0, 0);

    load(32'h4000_0000, WAVE_SINE, 16'h8000);
    step(1, 1, 1, 0, '0, 0, 0); run(11);
    load(32'h8000_0000, WAVE_SQUARE, 16'h4000);
    step(1, 1, 1, 0, '0, 0, 0); run(7);
    load(32'h0001_0000, WAVE_SAW, 16'h8000);
    step(1, 1, 1, 0, '0, 0, 0); run(5);
    load(32'h0001_0000, WAVE_TRI, 16'h8000);
    step(1, 1, 1, 0, '0, 0, 0); run(5);

    // reconfigure mid-period, then exactly on a carry cycle
    load(32'h1000_0000, WAVE_TRI, 16'h8000);
    step(1, 1, 1, 0, '0, 0, 0);
    ld_done = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 4)
        step(1, 1, 0, 1, 32'h2000_0000, WAVE_SAW, 16'h7000);
      else if (i >= 20 && !ld_done && will_carry()) begin
        step(1, 1, 0, 1, 32'h4000_0000, WAVE_SQUARE, 16'h8000);
        ld_done = 1'b1;
      end else
        run(1);
    end

    load($urandom, WAVE_SAW, 16'hFFFF);
    step(1, 1, 1, 0, '0, 0, 0); run(3);
    load(32'h0123_4567, int'($urandom_range(0, 3)), 16'h0000);
    step(1, 1, 1, 0, '0, 0, 0); run(5);

    for (int i = 0; i < 300; i++)
      step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 40) == 0,
           ($urandom % 25) == 0, $urandom, int'($urandom_range(0, 3)),
           ($urandom % 3 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 32768)));

    load(32'h2000_0000, WAVE_SINE, 16'h6000);
    step(1, 1, 1, 0, '0, 0, 0); run(3);
    do_reset();
    run(5);
    load(32'h3000_0000, WAVE_SINE, 16'h8000);
    step(1, 1, 1, 0, '0, 0, 0); run(10);

    repeat (6) step(0, 0, 0, 0, '0, 0, 0);
    done = 1'b1;
  end

  // monitor / scoreboard
  initial begin
    ent_t e;
    int   ew;
    while (!done) begin
      @(posedge clk); #3;
      if (!reset_n) begin
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_data_valid", int'(bus.data_valid), 0);
        chk("rst_wrap", int'(bus.wrap), 0);
        last_out = 0;
      end else begin
        while (wrap_q.size() > 0 && wrap_q[0].due < cyc) e = wrap_q.pop_front();
        ew = 0;
        if (wrap_q.size() > 0 && wrap_q[0].due == cyc) begin
          e = wrap_q.pop_front();
          ew = e.val;
        end
        chk("wrap", int'(bus.wrap), ew);

        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          chk("late_valid", 0, 1);
        end
        if (bus.data_valid) begin
          if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("data_out", int'($signed(bus.data_out)), e.val);
            last_out = e.val;
          end else begin
            chk("spurious_valid", 1, 0);
          end
        end else begin
          chk("hold", int'($signed(bus.data_out)), last_out);
          if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("missing_valid", 0, 1);
          end
        end
      end
    end
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
